// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder slice.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between producer, adder and consumer.
interface nibble_serial_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) ();

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/fourbit_adder.sv
// Combinational 4-bit adder with carry in and carry out.
module fourbit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide add done one nibble per cycle, LSB nibble first, through a single 4-bit adder.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  nibble_serial_adder_if.slave bus
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_t                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          sum_q, sum_d;
  logic                  cout_q, cout_d;

  logic [NIBBLE_W-1:0]   a_nib, b_nib, add_sum;
  logic                  add_cout;

  // Loop-based select keeps every part-select constant, also when NIBBLES is 1.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  fourbit_adder u_adder (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IdxW'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = add_sum;
        end
        carry_d = add_cout;
        if (idx_q == LastIdx) begin
          cout_d  = add_cout;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) & ~rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule
